// File: rtl/leaf_fanin_arbiter.sv
// Round-robin fan-in of N_SRC leaf streams into one single-entry output
// register with bubble-free pass-through and a running beat counter.
module leaf_fanin_arbiter #(
  parameter int DATA_W = 8,
  parameter int N_SRC  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        in_valid,
  output logic [N_SRC-1:0]        in_ready,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [2:0]              out_src,
  output logic [15:0]             beat_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_data;
  logic [2:0]          r_src;
  logic [2:0]          r_ptr;
  logic [15:0]         r_cnt;

  logic                w_win;
  logic                w_found;
  logic                w_take;
  logic [N_SRC-1:0]    w_grant;
  logic [2:0]          w_sel;
  logic [3:0]          w_idx;

  assign w_win = rst_n & ((r_state == EMPTY) | out_ready);

  // Search upward from the slot after the last winner, wrapping once.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int j = 1; j <= N_SRC; j++) begin
      w_idx = {1'b0, r_ptr} + 4'(j);
      if (w_idx >= 4'(N_SRC)) w_idx = w_idx - 4'(N_SRC);
      if (!w_found && in_valid[w_idx[2:0]]) begin
        w_found            = 1'b1;
        w_grant[w_idx[2:0]] = 1'b1;
        w_sel              = w_idx[2:0];
      end
    end
  end

  assign w_take   = w_win & w_found;
  assign in_ready = w_take ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY: if (w_take) w_next = FULL;
      FULL:  if (out_ready && !w_take) w_next = EMPTY;
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_src  <= '0;
      r_ptr  <= 3'(N_SRC - 1);
      r_cnt  <= '0;
    end else if (w_take) begin
      r_data <= in_data[w_sel*DATA_W +: DATA_W];
      r_src  <= w_sel;
      r_ptr  <= w_sel;
      r_cnt  <= r_cnt + 16'd1;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign beat_cnt  = r_cnt;

endmodule
